// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg
//   Shared types and constants for the instruction-side memory responder:
//   FSM state encodings, the default instruction-space base address, the
//   default NOP word, and the halfword window selector used by the line buffer.
package imem_responder_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE  = 2'd0,
        IMEM_REQ   = 2'd1,
        IMEM_WAIT  = 2'd2,
        IMEM_DRAIN = 2'd3
    } imem_state_e;

    localparam logic [63:0] PMEM_START   = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    // 32-bit window starting at halfword 'off' of a 64-bit word; halfwords
    // beyond the top of the word read as zero.
    function automatic logic [31:0] half_window(input logic [63:0] data,
                                                input logic [1:0]  off);
        logic [63:0] sh;
        sh = data >> {off, 4'b0000};
        return sh[31:0];
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if
//   64-bit word-addressed read port between the responder and instruction memory.
//   mem_req_o/mem_addr_o : read request and 8-byte aligned address (responder -> memory)
//   mem_gnt_i            : request accepted this cycle (memory -> responder)
//   mem_rvalid_i         : read data valid, one per grant (memory -> responder)
//   mem_rdata_i          : read data, little-endian (memory -> responder)
interface imem_responder_if;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/imem_responder_line_buf.sv
// imem_responder_line_buf
//   One-word instruction line buffer: tag/data/valid registers, tag compares
//   for the fetch word and the following word, and the halfword select mux.
//   clock, reset        : clock, synchronous active-high reset (clears valid only)
//   wr_en/wr_tag/wr_data: fill the buffer with a returned memory word
//   tag_p/tag_next      : tag of the fetch word and of the word after it
//   off                 : halfword offset of the fetch PC inside its word
//   hit/hit_next        : buffer holds tag_p / tag_next
//   window              : 32-bit window at 'off' (zero-filled past the word end)
//   top_half/bot_half   : buffered halfwords [63:48] and [15:0]
module imem_responder_line_buf
    import imem_responder_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [60:0] wr_tag,
    input  logic [63:0] wr_data,
    input  logic [60:0] tag_p,
    input  logic [60:0] tag_next,
    input  logic [1:0]  off,
    output logic        hit,
    output logic        hit_next,
    output logic [31:0] window,
    output logic [15:0] top_half,
    output logic [15:0] bot_half
);
    logic        buf_valid;
    logic [60:0] buf_tag;
    logic [63:0] buf_data;

    always_ff @(posedge clock) begin
        if (reset)
            buf_valid <= 1'b0;
        else if (wr_en)
            buf_valid <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_tag  <= wr_tag;
            buf_data <= wr_data;
        end
    end

    assign hit      = buf_valid && (buf_tag == tag_p);
    assign hit_next = buf_valid && (buf_tag == tag_next);
    assign window   = half_window(buf_data, off);
    assign top_half = buf_data[63:48];
    assign bot_half = buf_data[15:0];

endmodule

// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-side memory responder for the fetch stage. Returns the raw
//   32-bit window at pc_i from a one-word line buffer, fetching missing words
//   over a 64-bit memory port and assembling 32-bit instructions that straddle
//   an 8-byte boundary.
//   clock, reset : clock, synchronous active-high reset
//   pc_i         : fetch PC, held stable while stall_o=1 unless flush_i
//   flush_i      : fetch redirect, abandons the current miss
//   inst_o       : instruction bits at pc_i (NOP_INST when stalled/faulted)
//   stall_o      : inst_o not valid this cycle
//   fault_o      : access fault (odd PC, or outside the legal range)
//   mem          : memory read port (master side)
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter logic [63:0] PMEM_BASE = PMEM_START,
    parameter logic [63:0] PMEM_SIZE = 64'h0800_0000,
    parameter logic [31:0] NOP_INST  = NOP_INST_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [63:0]             pc_i,
    input  logic                    flush_i,
    output logic [31:0]             inst_o,
    output logic                    stall_o,
    output logic                    fault_o,
    imem_responder_if.master        mem
);
    function automatic logic in_range(input logic [63:0] a);
        // Subtract first so BASE+SIZE never has to be formed.
        return (a >= PMEM_BASE) && ((a - PMEM_BASE) < PMEM_SIZE);
    endfunction

    imem_state_e state, state_d;
    logic [60:0] req_tag, req_tag_d;
    logic        hi_pend, hi_pend_d;
    logic [15:0] lo16, lo16_d;
    logic [60:0] lo_tag, lo_tag_d;
    logic        lo_valid, lo_valid_d;
    logic        buf_wr;

    logic [60:0] tag_p, tag_next;
    logic [1:0]  off;
    logic        buf_hit, buf_hit_next, lo_hit, next_ok, span, fault_c;
    logic [31:0] buf_window;
    logic [15:0] buf_top, buf_bot;

    assign tag_p    = pc_i[63:3];
    assign off      = pc_i[2:1];
    assign tag_next = tag_p + 61'd1;
    // Tag wrap-around counts as out of range.
    assign next_ok  = (tag_p != {61{1'b1}}) && in_range({tag_next, 3'b000});

    imem_responder_line_buf u_line_buf (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (buf_wr),
        .wr_tag   (req_tag),
        .wr_data  (mem.mem_rdata_i),
        .tag_p    (tag_p),
        .tag_next (tag_next),
        .off      (off),
        .hit      (buf_hit),
        .hit_next (buf_hit_next),
        .window   (buf_window),
        .top_half (buf_top),
        .bot_half (buf_bot)
    );

    // lo16 keeps the low half of the last straddling instruction after the
    // buffer has moved on to the following word.
    assign lo_hit  = lo_valid && (lo_tag == tag_p);
    assign span    = (off == 2'b11) &&
                     ((buf_hit && (buf_top[1:0] == 2'b11)) ||
                      (lo_hit  && (lo16[1:0]    == 2'b11)));
    assign fault_c = pc_i[0] || !in_range(pc_i) || (span && !next_ok);

    assign mem.mem_addr_o = {req_tag, 3'b000};

    always_comb begin
        state_d    = state;
        req_tag_d  = req_tag;
        hi_pend_d  = hi_pend;
        lo16_d     = lo16;
        lo_tag_d   = lo_tag;
        lo_valid_d = lo_valid;
        buf_wr     = 1'b0;
        inst_o     = NOP_INST;
        stall_o    = 1'b0;
        fault_o    = 1'b0;
        mem.mem_req_o = 1'b0;

        case (state)
            IMEM_IDLE: begin
                if (fault_c) begin
                    fault_o = 1'b1;
                end else if (span) begin
                    if (lo_hit && buf_hit_next) begin
                        inst_o = {buf_bot, lo16};
                    end else begin
                        // Partial hit: low half from the buffer, fetch the next word.
                        stall_o = 1'b1;
                        if (buf_hit) begin
                            lo16_d     = buf_top;
                            lo_tag_d   = tag_p;
                            lo_valid_d = 1'b1;
                        end
                        req_tag_d = tag_next;
                        hi_pend_d = 1'b1;
                        state_d   = IMEM_REQ;
                    end
                end else if (buf_hit) begin
                    inst_o = buf_window;
                end else begin
                    stall_o   = 1'b1;
                    req_tag_d = tag_p;
                    hi_pend_d = 1'b0;
                    state_d   = IMEM_REQ;
                end
            end
            IMEM_REQ: begin
                stall_o       = 1'b1;
                mem.mem_req_o = 1'b1;
                if (flush_i)
                    // A grant in the flush cycle still owes us one response.
                    state_d = mem.mem_gnt_i ? IMEM_DRAIN : IMEM_IDLE;
                else if (mem.mem_gnt_i)
                    state_d = IMEM_WAIT;
            end
            IMEM_WAIT: begin
                stall_o = 1'b1;
                if (mem.mem_rvalid_i) begin
                    if (flush_i) begin
                        state_d = IMEM_IDLE;
                    end else begin
                        buf_wr = 1'b1;
                        if (!hi_pend && (req_tag == tag_p) && (off == 2'b11) &&
                            (mem.mem_rdata_i[49:48] == 2'b11) && next_ok) begin
                            lo16_d     = mem.mem_rdata_i[63:48];
                            lo_tag_d   = req_tag;
                            lo_valid_d = 1'b1;
                            req_tag_d  = req_tag + 61'd1;
                            hi_pend_d  = 1'b1;
                            state_d    = IMEM_REQ;
                        end else begin
                            state_d = IMEM_IDLE;
                        end
                    end
                end else if (flush_i) begin
                    state_d = IMEM_DRAIN;
                end
            end
            IMEM_DRAIN: begin
                stall_o = 1'b1;
                if (mem.mem_rvalid_i)
                    state_d = IMEM_IDLE;
            end
            default: state_d = IMEM_IDLE;
        endcase

        if (reset) begin
            inst_o        = NOP_INST;
            stall_o       = 1'b0;
            fault_o       = 1'b0;
            mem.mem_req_o = 1'b0;
            buf_wr        = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IMEM_IDLE;
            hi_pend  <= 1'b0;
            lo_valid <= 1'b0;
        end else begin
            state    <= state_d;
            hi_pend  <= hi_pend_d;
            lo_valid <= lo_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        req_tag <= req_tag_d;
        lo16    <= lo16_d;
        lo_tag  <= lo_tag_d;
    end

endmodule
